// File: rtl/comet_ii_memory_responder.sv
// rtl/comet_ii_memory_responder.sv - COMET II word-addressed memory with wait states and program loader
module comet_ii_memory_responder #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              init,
  input  logic [15:0]       adr,
  input  logic              adr_en,
  input  logic              we,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              rdy,
  output logic              busy,
  input  logic              ld_valid,
  input  logic [15:0]       ld_data,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  output logic              err
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOAD} state_e;

  state_e              state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic                we_q, we_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                rdy_q, rdy_d;
  logic                busy_q, busy_d;
  logic                ld_ready_q, ld_ready_d;
  logic [ADDR_W:0]     ld_count_q, ld_count_d;
  logic                err_q, err_d;

  logic [15:0]         mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [15:0]         mem_wdata;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    adr_d      = adr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rdy_d      = 1'b0;
    ld_count_d = ld_count_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_waddr  = adr_q;
    mem_wdata  = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (init) begin
          state_d    = S_LOAD;
          ld_count_d = '0;
        end else if (adr_en) begin
          adr_d   = adr[ADDR_W-1:0];
          we_d    = we;
          wdata_d = wdata;
          wcnt_d  = 4'(WAIT_CYC);
          state_d = S_WAIT;
          // High address bits are mirrored away but remembered as an error
          if ((adr >> ADDR_W) != 16'd0) err_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
          if (we_q) mem_we = 1'b1;
          else      rdata_d = mem[adr_q];
        end
      end
      S_LOAD: begin
        if (ld_valid && ld_ready_q) begin
          mem_we     = 1'b1;
          mem_waddr  = ld_count_q[ADDR_W-1:0];
          mem_wdata  = ld_data;
          ld_count_d = ld_count_q + 1'b1;
        end
        if (!init) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d != S_IDLE);
    ld_ready_d = (state_d == S_LOAD) && (ld_count_d < DEPTH_C);
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      adr_q      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      ld_ready_q <= 1'b0;
      ld_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      adr_q      <= adr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      ld_ready_q <= ld_ready_d;
      ld_count_q <= ld_count_d;
      err_q      <= err_d;
    end
  end

  // Contents survive reset; only state above is cleared
  always_ff @(posedge mclk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rdata    = rdata_q;
  assign rdy      = rdy_q;
  assign busy     = busy_q;
  assign ld_ready = ld_ready_q;
  assign ld_count = ld_count_q;
  assign err      = err_q;

endmodule
